ascon_arbiter: RTL and testbench

ASCON_ARBITER -- requirements
Module: ascon_arbiter

---
 rtl/ascon_arbiter.sv | 126 ++++++++++++
 tb/tb_ascon_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ascon_arbiter.sv
// ascon_arbiter: round-robin arbiter that hands one of two requesters' ASCON jobs to a single core
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_i             : per-requester job request (level)
//   key_i, nonce_i    : requester n at [128n+127:128n]
//   ad_size_i, pt_size_i, delay_i : requester n at slice n
//   gnt_o             : one-hot grant / FIFO routing select
//   done_o, err_o     : one-cycle completion / timeout pulses
//   busy_o            : job in flight
//   tag_o, tag_owner_o: tag of the last completed job and its requester
//   core_*_o          : latched job configuration and start strobe towards the core
//   core_ready_i, core_tag_valid_i, core_tag_i : core handshake and result
module ascon_arbiter #(
    parameter int DATA_AW     = 7,
    parameter int DELAY_WIDTH = 16,
    parameter int TIMEOUT_W   = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_i,
    input  logic [255:0]             key_i,
    input  logic [255:0]             nonce_i,
    input  logic [2*DATA_AW-1:0]     ad_size_i,
    input  logic [2*DATA_AW-1:0]     pt_size_i,
    input  logic [2*DELAY_WIDTH-1:0] delay_i,
    output logic [1:0]               gnt_o,
    output logic [1:0]               done_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic [127:0]             tag_o,
    output logic                     tag_owner_o,
    output logic [127:0]             core_key_o,
    output logic [127:0]             core_nonce_o,
    output logic [DATA_AW-1:0]       core_ad_size_o,
    output logic [DATA_AW-1:0]       core_pt_size_o,
    output logic [DELAY_WIDTH-1:0]   core_delay_o,
    output logic                     core_start_o,
    input  logic                     core_ready_i,
    input  logic                     core_tag_valid_i,
    input  logic [127:0]             core_tag_i
);
    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, RUN} state_t;
    localparam logic [TIMEOUT_W-1:0] LIMIT    = '1;
    localparam logic [TIMEOUT_W-1:0] LIMIT_M1 = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] ONE      = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    state_t                   r_state, w_next;
    logic [1:0]               r_gnt, r_done;
    logic                     r_err, r_win, r_last, r_owner;
    logic [127:0]             r_tag, r_key, r_nonce;
    logic [DATA_AW-1:0]       r_ad, r_pt;
    logic [DELAY_WIDTH-1:0]   r_delay;
    logic [TIMEOUT_W-1:0]     r_timer;
    logic                     w_sel, w_grant, w_tag_done, w_timeout;
    always_comb begin
        // both requesting: the one not served last wins
        w_sel      = (req_i == 2'b11) ? ~r_last : req_i[1];
        w_grant    = (r_state == IDLE) && core_ready_i && (req_i != 2'b00);
        w_tag_done = (r_state == RUN) && core_tag_valid_i;
        // the timer would reach its limit at this edge; a tag in the same cycle takes precedence
        w_timeout  = (r_state == WAIT_ACK || r_state == RUN) && !w_tag_done && (r_timer >= LIMIT_M1);
        w_next     = r_state;
        case (r_state)
            IDLE:     w_next = w_grant ? START : IDLE;
            START:    w_next = WAIT_ACK;
            WAIT_ACK: w_next = w_timeout ? IDLE : (core_ready_i ? WAIT_ACK : RUN);
            RUN:      w_next = (w_tag_done || w_timeout) ? IDLE : RUN;
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_err   <= 1'b0;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_tag   <= '0;
            r_key   <= '0;
            r_nonce <= '0;
            r_ad    <= '0;
            r_pt    <= '0;
            r_delay <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 2'b00;
            r_err   <= 1'b0;
            if (w_grant) begin
                r_gnt   <= w_sel ? 2'b10 : 2'b01;
                r_win   <= w_sel;
                r_key   <= w_sel ? key_i[255:128] : key_i[127:0];
                r_nonce <= w_sel ? nonce_i[255:128] : nonce_i[127:0];
                r_ad    <= w_sel ? ad_size_i[2*DATA_AW-1:DATA_AW] : ad_size_i[DATA_AW-1:0];
                r_pt    <= w_sel ? pt_size_i[2*DATA_AW-1:DATA_AW] : pt_size_i[DATA_AW-1:0];
                r_delay <= w_sel ? delay_i[2*DELAY_WIDTH-1:DELAY_WIDTH] : delay_i[DELAY_WIDTH-1:0];
                r_timer <= '0;
            end else if (r_state == WAIT_ACK || r_state == RUN) begin
                r_timer <= (r_timer == LIMIT) ? r_timer : r_timer + ONE;
            end
            if (w_tag_done) begin
                r_tag   <= core_tag_i;
                r_owner <= r_win;
                r_last  <= r_win;
                r_done  <= r_gnt;
                r_gnt   <= 2'b00;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
                r_gnt <= 2'b00;
            end
        end
    end
    assign gnt_o          = r_gnt;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign busy_o         = (r_state != IDLE);
    assign core_start_o   = (r_state == START);
    assign tag_o          = r_tag;
    assign tag_owner_o    = r_owner;
    assign core_key_o     = r_key;
    assign core_nonce_o   = r_nonce;
    assign core_ad_size_o = r_ad;
    assign core_pt_size_o = r_pt;
    assign core_delay_o   = r_delay;
endmodule

// File: tb/tb_ascon_arbiter.sv
// tb_ascon_arbiter: directed and randomized jobs checked against a behavioural arbiter model
module tb_ascon_arbiter;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int TW = 6;
    localparam int LIMIT = (1 << TW) - 1;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] req_i, gnt_o, done_o;
    logic [255:0] key_i, nonce_i;
    logic [2*AW-1:0] ad_size_i, pt_size_i;
    logic [2*DW-1:0] delay_i;
    logic err_o, busy_o, tag_owner_o, core_start_o, core_ready_i, core_tag_valid_i;
    logic [127:0] tag_o, core_key_o, core_nonce_o, core_tag_i;
    logic [AW-1:0] core_ad_size_o, core_pt_size_o;
    logic [DW-1:0] core_delay_o;
    int n_chk = 0;
    int n_err = 0;
    int m_last, m_owner;
    logic [127:0] m_tag;
    ascon_arbiter #(.DATA_AW(AW), .DELAY_WIDTH(DW), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .key_i(key_i), .nonce_i(nonce_i),
        .ad_size_i(ad_size_i), .pt_size_i(pt_size_i), .delay_i(delay_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .tag_o(tag_o), .tag_owner_o(tag_owner_o),
        .core_key_o(core_key_o), .core_nonce_o(core_nonce_o), .core_ad_size_o(core_ad_size_o),
        .core_pt_size_o(core_pt_size_o), .core_delay_o(core_delay_o), .core_start_o(core_start_o),
        .core_ready_i(core_ready_i), .core_tag_valid_i(core_tag_valid_i), .core_tag_i(core_tag_i)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [319:0] obs, input logic [319:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", nm, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [255:0] r256();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction
    task automatic scramble();
        key_i = r256();
        nonce_i = r256();
        ad_size_i = (2*AW)'($urandom());
        pt_size_i = (2*AW)'($urandom());
        delay_i = (2*DW)'($urandom());
    endtask
    task automatic job(input logic [1:0] rq, input int ack_lat, input int tag_lat, input bit drop, input logic [127:0] tg);
        int w, tc;
        bit fin;
        logic [319:0] ecfg;
        scramble();
        req_i = rq;
        core_ready_i = 1'b1;
        core_tag_valid_i = 1'b0;
        w = (rq == 2'b11) ? 1 - m_last : (rq == 2'b10 ? 1 : 0);
        ecfg = {key_i[128*w +: 128], nonce_i[128*w +: 128], ad_size_i[AW*w +: AW], pt_size_i[AW*w +: AW], delay_i[DW*w +: DW]};
        step();
        chk("grant", gnt_o, 2'b01 << w);
        chk("start_on", core_start_o, 1);
        chk("busy_start", busy_o, 1);
        chk("cfg_grant", {core_key_o, core_nonce_o, core_ad_size_o, core_pt_size_o, core_delay_o}, ecfg);
        if (drop) begin
            scramble();
            req_i = 2'($urandom());
        end
        step();
        chk("start_off", core_start_o, 0);
        tc = ack_lat + 1 + tag_lat;
        fin = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            core_ready_i = (c < ack_lat) || (c >= tc);
            core_tag_valid_i = (c == tc);
            core_tag_i = (c == tc) ? tg : r256()[127:0];
            if (drop) begin
                scramble();
                req_i = 2'($urandom());
            end
            step();
            if (c == tc && c <= LIMIT - 1) begin
                chk("done", {done_o, err_o, gnt_o, busy_o}, {2'b01 << w, 1'b0, 2'b00, 1'b0});
                chk("tag", {tag_o, tag_owner_o}, {tg, 1'(w)});
                m_tag = tg;
                m_owner = w;
                m_last = w;
                fin = 1;
            end else if (c == LIMIT - 1) begin
                chk("timeout", {done_o, err_o, gnt_o, busy_o}, {2'b00, 1'b1, 2'b00, 1'b0});
                chk("tag_kept", {tag_o, tag_owner_o}, {m_tag, 1'(m_owner)});
                fin = 1;
            end else begin
                chk("in_flight", {done_o, err_o, gnt_o, busy_o, core_start_o}, {2'b00, 1'b0, 2'b01 << w, 1'b1, 1'b0});
                chk("cfg_hold", {core_key_o, core_nonce_o, core_ad_size_o, core_pt_size_o, core_delay_o}, ecfg);
            end
        end
        if (!fin) chk("job_bound", 0, 1);
        core_tag_valid_i = 1'b0;
        core_ready_i = 1'b1;
        req_i = 2'b00;
    endtask
    initial begin
        rst_n = 1'b0;
        req_i = 2'b00;
        core_ready_i = 1'b0;
        core_tag_valid_i = 1'b0;
        core_tag_i = '0;
        scramble();
        m_last = 1;
        m_owner = 0;
        m_tag = '0;
        #12;
        chk("rst_out", {gnt_o, done_o, err_o, busy_o, core_start_o, tag_owner_o, tag_o}, 0);
        chk("rst_cfg", {core_key_o, core_nonce_o, core_ad_size_o, core_pt_size_o, core_delay_o}, 0);
        rst_n = 1'b1;
        core_ready_i = 1'b1;
        step();
        chk("idle_after_rst", {gnt_o, busy_o}, 0);
        job(2'b01, 2, 27, 0, {16{8'hA5}});
        step();
        chk("done_one_cycle", {done_o, err_o}, 0);
        for (int i = 0; i < 4; i++) job(2'b11, $urandom_range(0, 4), $urandom_range(0, 10), 0, r256()[127:0]);
        req_i = 2'b10;
        core_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("not_ready", {gnt_o, core_start_o, busy_o}, 0);
        end
        job(2'b10, 1, 5, 0, r256()[127:0]);
        job(2'b01, 3, 500, 0, r256()[127:0]);
        step();
        chk("err_one_cycle", {done_o, err_o}, 0);
        job(2'b10, 2, LIMIT - 4, 0, r256()[127:0]);
        job(2'b01, 3, 8, 1, r256()[127:0]);
        for (int i = 0; i < 10; i++)
            job(2'($urandom_range(1, 3)), $urandom_range(0, 6), $urandom_range(0, 70), $urandom_range(0, 1), r256()[127:0]);
        req_i = 2'b01;
        core_ready_i = 1'b1;
        step();
        step();
        core_ready_i = 1'b0;
        step();
        step();
        chk("run_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out", {gnt_o, done_o, err_o, busy_o, core_start_o, tag_owner_o, tag_o}, 0);
        chk("rst_mid_cfg", {core_key_o, core_nonce_o, core_ad_size_o, core_pt_size_o, core_delay_o}, 0);
        m_last = 1;
        m_owner = 0;
        m_tag = '0;
        step();
        rst_n = 1'b1;
        job(2'b11, 1, 4, 0, r256()[127:0]);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
